// File: rtl/lag_pl_credit_free_pool_if.sv
// Link/allocator-facing bundle of the per-port PL free pool.
// master: output-port link and PL allocator; slave: the free pool itself.
interface lag_pl_credit_free_pool_if #(
  parameter int NUM_PLS_GLOBAL = 4
);
  localparam int CNT_W = $clog2(NUM_PLS_GLOBAL + 1);

  logic [NUM_PLS_GLOBAL-1:0] flit_valid;
  logic [NUM_PLS_GLOBAL-1:0] flit_tail;
  logic [NUM_PLS_GLOBAL-1:0] credit_return;
  logic [NUM_PLS_GLOBAL-1:0] pl_allocated;
  logic [NUM_PLS_GLOBAL-1:0] pl_alloc_status;
  logic [NUM_PLS_GLOBAL-1:0] pl_credit_avail;
  logic [NUM_PLS_GLOBAL-1:0] pl_empty;
  logic [CNT_W-1:0]          free_count;
  logic                      error;

  modport master (
    output flit_valid, flit_tail, credit_return, pl_allocated,
    input  pl_alloc_status, pl_credit_avail, pl_empty, free_count, error
  );

  modport slave (
    input  flit_valid, flit_tail, credit_return, pl_allocated,
    output pl_alloc_status, pl_credit_avail, pl_empty, free_count, error
  );
endinterface

// File: rtl/lag_pl_credit_free_pool.sv
// Per-output-port packet-lane free pool with downstream credit tracking.
// Offers free PLs either all at once or oldest-first from a circular id queue.
module lag_pl_credit_free_pool #(
  parameter int NUM_PLS_GLOBAL   = 4,
  parameter int NUM_PLS_LOCAL    = 4,
  parameter int BUF_DEPTH        = 4,
  parameter int FIFO_MODE        = 0,
  parameter int ALLOC_WHEN_EMPTY = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  lag_pl_credit_free_pool_if.slave bus
);

  localparam int N  = NUM_PLS_GLOBAL;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = $clog2(N + 1);

  localparam logic [CW-1:0] FULL_CRED  = CW'(BUF_DEPTH);
  localparam logic [N-1:0]  LOCAL_MASK = N'((64'd1 << NUM_PLS_LOCAL) - 64'd1);

  logic [CW-1:0] credit_q [N];
  logic [CW-1:0] credit_d [N];
  logic [N-1:0]  free_q, free_d;
  logic          error_q, error_d;
  logic [IW-1:0] queue_q [N];
  logic [IW-1:0] queue_d [N];
  logic [IW-1:0] head_q, head_d;
  logic [IW-1:0] tail_q, tail_d;
  logic [FW-1:0] count_q, count_d;

  logic [N-1:0]  credit_avail, empty;
  logic [N-1:0]  fifo_offer, unr_offer, offer;
  logic [FW-1:0] free_pop;
  logic [IW-1:0] head_id;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    if (p == IW'(N - 1)) return '0;
    return p + IW'(1);
  endfunction

  // Offer and status outputs, purely from registered state.
  always_comb begin
    credit_avail = '0;
    empty        = '0;
    free_pop     = '0;
    for (int i = 0; i < N; i++) begin
      credit_avail[i] = (credit_q[i] != '0);
      empty[i]        = (credit_q[i] == FULL_CRED);
      free_pop        = free_pop + FW'(free_q[i]);
    end
    head_id    = queue_q[head_q];
    fifo_offer = '0;
    if (count_q != '0 && (ALLOC_WHEN_EMPTY == 0 || empty[head_id])) begin
      fifo_offer[head_id] = 1'b1;
    end
    unr_offer = free_q & ((ALLOC_WHEN_EMPTY != 0) ? empty : '1);
    offer     = (FIFO_MODE != 0) ? fifo_offer : unr_offer;
  end

  assign bus.pl_alloc_status = offer;
  assign bus.pl_credit_avail = credit_avail;
  assign bus.pl_empty        = empty;
  assign bus.free_count      = (FIFO_MODE != 0) ? count_q : free_pop;
  assign bus.error           = error_q;

  logic [N-1:0]  tail_ev, local_tails;
  logic          err, pop, push;
  logic [IW-1:0] push_id;
  logic [FW-1:0] count_after_pop;

  // Next-state: credits, free flags, queue pointers and protocol checks.
  always_comb begin
    err     = 1'b0;
    tail_ev = bus.flit_valid & bus.flit_tail;
    free_d  = free_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < N; i++) begin
      queue_d[i]  = queue_q[i];
      credit_d[i] = credit_q[i];
    end

    // Non-local PLs must stay silent; their state is never touched.
    if (((bus.flit_valid | bus.credit_return | bus.pl_allocated) & ~LOCAL_MASK) != '0) begin
      err = 1'b1;
    end

    for (int i = 0; i < N; i++) begin
      if (i < NUM_PLS_LOCAL) begin
        if (bus.flit_valid[i] && !bus.credit_return[i]) begin
          if (credit_q[i] == '0) err = 1'b1;
          else credit_d[i] = credit_q[i] - CW'(1);
        end else if (bus.credit_return[i] && !bus.flit_valid[i]) begin
          if (credit_q[i] == FULL_CRED) err = 1'b1;
          else credit_d[i] = credit_q[i] + CW'(1);
        end
        // Tail beats a same-cycle allocation (single-flit packet).
        if (tail_ev[i]) begin
          if (free_q[i] && !bus.pl_allocated[i]) err = 1'b1;
          free_d[i] = 1'b1;
        end else if (bus.pl_allocated[i]) begin
          free_d[i] = 1'b0;
        end
      end
    end

    local_tails     = tail_ev & LOCAL_MASK;
    pop             = 1'b0;
    push            = 1'b0;
    push_id         = '0;
    count_after_pop = count_q;

    if (FIFO_MODE == 0) begin
      if ((bus.pl_allocated & ~offer & LOCAL_MASK) != '0) err = 1'b1;
    end else begin
      if (bus.pl_allocated != '0) begin
        if (bus.pl_allocated == offer) pop = 1'b1;
        else err = 1'b1;
      end
      if ((local_tails & (local_tails - N'(1))) != '0) err = 1'b1;
      for (int i = N - 1; i >= 0; i--) begin
        if (local_tails[i]) push_id = IW'(i);
      end
      push = (local_tails != '0);

      // Pop first so a re-queued single-flit PL lands behind the others.
      if (pop) begin
        head_d          = ptr_inc(head_q);
        count_after_pop = count_q - FW'(1);
      end
      count_d = count_after_pop;
      if (push) begin
        if (count_after_pop == FW'(N)) begin
          err = 1'b1;
        end else begin
          queue_d[tail_q] = push_id;
          tail_d          = ptr_inc(tail_q);
          count_d         = count_after_pop + FW'(1);
        end
      end
    end

    error_d = error_q | err;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        credit_q[i] <= (i < NUM_PLS_LOCAL) ? FULL_CRED : '0;
        queue_q[i]  <= IW'(i);
      end
      free_q  <= LOCAL_MASK;
      error_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= IW'(NUM_PLS_LOCAL % N);
      count_q <= FW'(NUM_PLS_LOCAL);
    end else begin
      for (int i = 0; i < N; i++) begin
        credit_q[i] <= credit_d[i];
        queue_q[i]  <= queue_d[i];
      end
      free_q  <= free_d;
      error_q <= error_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_lag_pl_credit_free_pool.sv
// Randomized bench for the PL free pool: four configurations driven in lockstep,
// each compared every cycle against a list-based behavioural model.
module tb_lag_pl_credit_free_pool;

  localparam int NG = 4;
  localparam int BD = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0] i_fv [NG];
  logic [3:0] i_ft [NG];
  logic [3:0] i_cr [NG];
  logic [3:0] i_pa [NG];
  logic [3:0] o_status [NG];
  logic [3:0] o_cavail [NG];
  logic [3:0] o_empty [NG];
  logic [2:0] o_fcnt [NG];
  logic       o_err [NG];

  // g0: unrestricted, 2 local; g1: unrestricted+empty-only, 3 local;
  // g2: FIFO, 4 local; g3: FIFO+empty-only, 3 local.
  for (genvar g = 0; g < NG; g++) begin : g_dut
    localparam int LOC = (g == 0) ? 2 : ((g == 2) ? 4 : 3);
    lag_pl_credit_free_pool_if #(.NUM_PLS_GLOBAL(4)) bus ();
    assign bus.flit_valid    = i_fv[g];
    assign bus.flit_tail     = i_ft[g];
    assign bus.credit_return = i_cr[g];
    assign bus.pl_allocated  = i_pa[g];
    assign o_status[g] = bus.pl_alloc_status;
    assign o_cavail[g] = bus.pl_credit_avail;
    assign o_empty[g]  = bus.pl_empty;
    assign o_fcnt[g]   = bus.free_count;
    assign o_err[g]    = bus.error;
    lag_pl_credit_free_pool #(
      .NUM_PLS_GLOBAL  (4),
      .NUM_PLS_LOCAL   (LOC),
      .BUF_DEPTH       (BD),
      .FIFO_MODE       (g / 2),
      .ALLOC_WHEN_EMPTY(g % 2)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );
  end

  function automatic int cfg_loc(input int g);
    return (g == 0) ? 2 : ((g == 2) ? 4 : 3);
  endfunction
  function automatic bit cfg_fifo(input int g);
    return g >= 2;
  endfunction
  function automatic bit cfg_awe(input int g);
    return (g % 2) == 1;
  endfunction

  // Model: credits as integers, free flags, ordered list of queued ids.
  int mcred [NG][4];
  bit mfree [NG][4];
  bit merr  [NG];
  int mq    [NG][4];
  int mlen  [NG];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset(input int g);
    for (int i = 0; i < 4; i++) begin
      mfree[g][i] = (i < cfg_loc(g));
      mcred[g][i] = (i < cfg_loc(g)) ? BD : 0;
      mq[g][i]    = i;
    end
    mlen[g] = cfg_loc(g);
    merr[g] = 1'b0;
  endtask

  function automatic logic [3:0] m_offer(input int g);
    logic [3:0] o = '0;
    if (cfg_fifo(g)) begin
      if (mlen[g] > 0 && (!cfg_awe(g) || mcred[g][mq[g][0]] == BD)) o[mq[g][0]] = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++)
        if (mfree[g][i] && (!cfg_awe(g) || mcred[g][i] == BD)) o[i] = 1'b1;
    end
    return o;
  endfunction

  function automatic int m_free_count(input int g);
    int c = 0;
    if (cfg_fifo(g)) return mlen[g];
    for (int i = 0; i < 4; i++) c += int'(mfree[g][i]);
    return c;
  endfunction

  task automatic m_step(input int g, input logic [3:0] fv, input logic [3:0] ft,
                        input logic [3:0] cr, input logic [3:0] pa);
    logic [3:0] offer;
    logic [3:0] tails;
    int ntails;
    bit e;
    offer  = m_offer(g);
    e      = 1'b0;
    tails  = fv & ft;
    ntails = 0;
    for (int i = 0; i < 4; i++) begin
      if (i >= cfg_loc(g)) begin
        if (fv[i] || cr[i] || pa[i]) e = 1'b1;
        tails[i] = 1'b0;
        continue;
      end
      if (fv[i] && !cr[i]) begin
        if (mcred[g][i] == 0) e = 1'b1; else mcred[g][i]--;
      end else if (cr[i] && !fv[i]) begin
        if (mcred[g][i] == BD) e = 1'b1; else mcred[g][i]++;
      end
      if (tails[i]) begin
        if (mfree[g][i] && !pa[i]) e = 1'b1;
        mfree[g][i] = 1'b1;
        ntails++;
      end else if (pa[i]) begin
        mfree[g][i] = 1'b0;
      end
    end
    if (!cfg_fifo(g)) begin
      if ((pa & ~offer) != 0) e = 1'b1;
    end else begin
      if (pa != 0) begin
        if (pa == offer) begin
          for (int k = 0; k < 3; k++) mq[g][k] = mq[g][k+1];
          mlen[g]--;
        end else begin
          e = 1'b1;
        end
      end
      if (ntails > 1) e = 1'b1;
      if (ntails > 0) begin
        int id = 0;
        for (int i = 3; i >= 0; i--) if (tails[i]) id = i;
        if (mlen[g] == 4) e = 1'b1;
        else begin
          mq[g][mlen[g]] = id;
          mlen[g]++;
        end
      end
    end
    if (e) merr[g] = 1'b1;
  endtask

  // Protocol-respecting stimulus derived from the model's view of the port.
  task automatic gen_legal(input int g, output logic [3:0] fv, output logic [3:0] ft,
                           output logic [3:0] cr, output logic [3:0] pa);
    logic [3:0] offer;
    offer = m_offer(g);
    fv = '0; ft = '0; cr = '0; pa = '0;
    if (offer != 0 && $urandom_range(0, 2) == 0) begin
      if (cfg_fifo(g)) pa = offer;
      else pa = offer & 4'($urandom);
    end
    for (int i = 0; i < cfg_loc(g); i++) begin
      if ((!mfree[g][i] || pa[i]) && mcred[g][i] > 0 && $urandom_range(0, 1) == 0) begin
        fv[i] = 1'b1;
        if ($urandom_range(0, 3) == 0) ft[i] = 1'b1;
      end
      if ((mcred[g][i] < BD || fv[i]) && $urandom_range(0, 2) == 0) cr[i] = 1'b1;
    end
    if (cfg_fifo(g)) ft = ft & (~ft + 4'd1);
  endtask

  task automatic check_all(input int g, input int cyc);
    check_eq($sformatf("g%0d status c%0d", g, cyc), 32'(o_status[g]), 32'(m_offer(g)));
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("g%0d cavail%0d c%0d", g, i, cyc), 32'(o_cavail[g][i]),
               32'(mcred[g][i] > 0));
      check_eq($sformatf("g%0d empty%0d c%0d", g, i, cyc), 32'(o_empty[g][i]),
               32'(mcred[g][i] == BD));
    end
    check_eq($sformatf("g%0d free_count c%0d", g, cyc), 32'(o_fcnt[g]), 32'(m_free_count(g)));
    check_eq($sformatf("g%0d error c%0d", g, cyc), 32'(o_err[g]), 32'(merr[g]));
  endtask

  initial begin
    logic [3:0] fv, ft, cr, pa;
    bit do_rst;
    rst_n = 1'b0;
    for (int g = 0; g < NG; g++) begin
      i_fv[g] = '0; i_ft[g] = '0; i_cr[g] = '0; i_pa[g] = '0;
      m_reset(g);
    end
    @(posedge clk); #1;
    check_eq("rst g0 status", 32'(o_status[0]), 32'h3);
    check_eq("rst g0 empty", 32'(o_empty[0]), 32'h3);
    check_eq("rst g0 free_count", 32'(o_fcnt[0]), 32'd2);
    check_eq("rst g0 error", 32'(o_err[0]), 32'd0);
    check_eq("rst g2 status", 32'(o_status[2]), 32'h1);
    check_eq("rst g2 free_count", 32'(o_fcnt[2]), 32'd4);
    for (int g = 0; g < NG; g++) check_all(g, 0);
    rst_n = 1'b1;

    for (int cyc = 1; cyc <= 3000; cyc++) begin
      do_rst = ($urandom_range(0, 79) == 0);
      for (int g = 0; g < NG; g++) begin
        if ($urandom_range(0, 149) == 0) begin
          fv = 4'($urandom); ft = 4'($urandom); cr = 4'($urandom); pa = 4'($urandom);
        end else begin
          gen_legal(g, fv, ft, cr, pa);
        end
        i_fv[g] = fv; i_ft[g] = ft; i_cr[g] = cr; i_pa[g] = pa;
      end
      rst_n = !do_rst;
      @(posedge clk); #1;
      for (int g = 0; g < NG; g++) begin
        if (do_rst) m_reset(g);
        else m_step(g, i_fv[g], i_ft[g], i_cr[g], i_pa[g]);
        check_all(g, cyc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
